pbch_descrambler: RTL and testbench

PBCH_DESCRAMBLER -- requirements
Module: pbch_descrambler

---
 rtl/pbch_descrambler_pkg.sv | 26 ++
 rtl/pbch_descrambler_gold_seq_gen.sv | 40 ++++
 rtl/pbch_descrambler.sv | 136 +++++++++++++
 tb/tb_pbch_descrambler.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pbch_descrambler_pkg.sv
// rtl/pbch_descrambler_pkg.sv - shared receiver constants, FSM state type and Gold LFSR helpers
package pbch_descrambler_pkg;

    localparam int NC               = 1600;
    localparam int PBCH_LEN_DEFAULT = 864;
    localparam int GOLD_W           = 31;

    // Feedback taps: x1(n+31) = x1(n+3)+x1(n); x2(n+31) = x2(n+3)+x2(n+2)+x2(n+1)+x2(n)
    localparam logic [GOLD_W-1:0] X1_TAPS = 31'h0000_0009;
    localparam logic [GOLD_W-1:0] X2_TAPS = 31'h0000_000F;
    localparam logic [GOLD_W-1:0] X1_INIT = 31'h0000_0001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        READY = 2'd2,
        RUN   = 2'd3
    } pbch_state_e;

    // Bit 0 holds x(n); one call advances the register to x(n+1..n+31).
    function automatic logic [GOLD_W-1:0] gold_step(input logic [GOLD_W-1:0] x,
                                                    input logic [GOLD_W-1:0] taps);
        return {^(x & taps), x[GOLD_W-1:1]};
    endfunction

endpackage

// File: rtl/pbch_descrambler_gold_seq_gen.sv
// rtl/pbch_descrambler_gold_seq_gen.sv - Gold sequence LFSR pair, one c(n) bit per step
module gold_seq_gen
    import pbch_descrambler_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              load_i,
    input  logic [GOLD_W-1:0] c_init_i,
    input  logic              step_i,
    output logic              c_out_o
);

    logic [GOLD_W-1:0] x1_q, x1_d;
    logic [GOLD_W-1:0] x2_q, x2_d;

    always_comb begin
        x1_d = x1_q;
        x2_d = x2_q;
        if (load_i) begin
            x1_d = X1_INIT;
            x2_d = c_init_i;
        end else if (step_i) begin
            x1_d = gold_step(x1_q, X1_TAPS);
            x2_d = gold_step(x2_q, X2_TAPS);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            x1_q <= '0;
            x2_q <= '0;
        end else begin
            x1_q <= x1_d;
            x2_q <= x2_d;
        end
    end

    assign c_out_o = x1_q[0] ^ x2_q[0];

endmodule

// File: rtl/pbch_descrambler.sv
// rtl/pbch_descrambler.sv - PBCH LLR descrambler: Gold sequence sign flip with saturating negation
module pbch_descrambler
    import pbch_descrambler_pkg::*;
#(
    parameter int LLR_DW   = 8,
    parameter int PBCH_LEN = PBCH_LEN_DEFAULT,
    parameter int N_ID_DW  = 10
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [N_ID_DW-1:0] N_id_i,
    input  logic               N_id_valid_i,
    input  logic [2:0]         ibar_SSB_i,
    input  logic               ibar_SSB_valid_i,
    input  logic [LLR_DW-1:0]  s_axis_llr_in_tdata,
    input  logic [1:0]         s_axis_llr_in_tuser,
    input  logic               s_axis_llr_in_tlast,
    input  logic               s_axis_llr_in_tvalid,
    output logic [LLR_DW-1:0]  m_axis_llr_out_tdata,
    output logic [1:0]         m_axis_llr_out_tuser,
    output logic               m_axis_llr_out_tlast,
    output logic               m_axis_llr_out_tvalid,
    output logic               ready_o,
    output logic               dropped_o
);

    localparam int CNT_W  = $clog2(PBCH_LEN);
    localparam int INIT_W = $clog2(NC + 3 * PBCH_LEN + 1);
    localparam logic [LLR_DW-1:0] LLR_MIN = {1'b1, {(LLR_DW-1){1'b0}}};
    localparam logic [LLR_DW-1:0] LLR_MAX = {1'b0, {(LLR_DW-1){1'b1}}};

    pbch_state_e         state_q, state_d;
    logic [N_ID_DW-1:0]  n_id_q, n_id_d;
    logic [1:0]          v_q, v_d, v_act_q, v_act_d;
    logic [INIT_W-1:0]   init_cnt_q, init_cnt_d, init_target;
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [LLR_DW-1:0]   tdata_q, neg_llr;
    logic [1:0]          tuser_q;
    logic                tlast_q, tvalid_q, dropped_q;
    logic                active, accept, drop, last_beat;
    logic                lfsr_load, lfsr_step, c_bit;
    logic                unused_ibar_msb;

    assign unused_ibar_msb = ibar_SSB_i[2];

    assign v_d         = ibar_SSB_valid_i ? ibar_SSB_i[1:0] : v_q;
    assign n_id_d      = N_id_valid_i ? N_id_i : n_id_q;
    assign active      = (state_q == READY) || (state_q == RUN);
    assign accept      = s_axis_llr_in_tvalid && active && !N_id_valid_i;
    assign drop        = s_axis_llr_in_tvalid && !accept;
    assign last_beat   = s_axis_llr_in_tlast || (beat_cnt_q == CNT_W'(PBCH_LEN - 1));
    assign init_target = INIT_W'(NC) + INIT_W'(v_act_q) * INIT_W'(PBCH_LEN);
    assign neg_llr     = (s_axis_llr_in_tdata == LLR_MIN) ? LLR_MAX : -s_axis_llr_in_tdata;

    // Every INIT entry reloads the LFSRs so each block restarts from c_init.
    always_comb begin
        state_d    = state_q;
        v_act_d    = v_act_q;
        init_cnt_d = init_cnt_q;
        beat_cnt_d = beat_cnt_q;
        lfsr_load  = 1'b0;
        lfsr_step  = 1'b0;
        if (N_id_valid_i || (accept && last_beat)) begin
            state_d    = INIT;
            v_act_d    = v_d;
            init_cnt_d = '0;
            beat_cnt_d = '0;
            lfsr_load  = 1'b1;
        end else begin
            case (state_q)
                INIT: begin
                    lfsr_step  = 1'b1;
                    init_cnt_d = init_cnt_q + INIT_W'(1);
                    if (init_cnt_q == init_target - INIT_W'(1)) begin
                        state_d = READY;
                    end
                end
                READY, RUN: begin
                    if (accept) begin
                        state_d    = RUN;
                        lfsr_step  = 1'b1;
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            n_id_q     <= '0;
            v_q        <= '0;
            v_act_q    <= '0;
            init_cnt_q <= '0;
            beat_cnt_q <= '0;
            tdata_q    <= '0;
            tuser_q    <= '0;
            tlast_q    <= 1'b0;
            tvalid_q   <= 1'b0;
            dropped_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_id_q     <= n_id_d;
            v_q        <= v_d;
            v_act_q    <= v_act_d;
            init_cnt_q <= init_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            tvalid_q   <= accept;
            tlast_q    <= accept && last_beat;
            dropped_q  <= drop;
            if (accept) begin
                tdata_q <= c_bit ? neg_llr : s_axis_llr_in_tdata;
                tuser_q <= s_axis_llr_in_tuser;
            end
        end
    end

    gold_seq_gen u_gold (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .load_i   (lfsr_load),
        .c_init_i (GOLD_W'(n_id_d)),
        .step_i   (lfsr_step),
        .c_out_o  (c_bit)
    );

    assign m_axis_llr_out_tdata  = tdata_q;
    assign m_axis_llr_out_tuser  = tuser_q;
    assign m_axis_llr_out_tlast  = tlast_q;
    assign m_axis_llr_out_tvalid = tvalid_q;
    assign ready_o               = active;
    assign dropped_o             = dropped_q;

endmodule

// File: tb/tb_pbch_descrambler.sv
// tb/tb_pbch_descrambler.sv - randomized self-checking bench for pbch_descrambler
module tb_pbch_descrambler;

    localparam int LLR_DW   = 8;
    localparam int PBCH_LEN = 864;
    localparam int N_ID_DW  = 10;
    localparam int NC_REF   = 1600;
    localparam int SEQ_N    = NC_REF + 4 * PBCH_LEN + 31;
    localparam int WAIT_MAX = 6000;

    logic              clk_i = 1'b0;
    logic              reset_i;
    logic [N_ID_DW-1:0] N_id_i;
    logic              N_id_valid_i;
    logic [2:0]        ibar_SSB_i;
    logic              ibar_SSB_valid_i;
    logic [LLR_DW-1:0] s_tdata;
    logic [1:0]        s_tuser;
    logic              s_tlast, s_tvalid;
    logic [LLR_DW-1:0] m_tdata;
    logic [1:0]        m_tuser;
    logic              m_tlast, m_tvalid;
    logic              ready_o, dropped_o;

    int vectors = 0;
    int miscompares = 0;
    int cur_nid;
    bit x1 [0:SEQ_N-1];
    bit x2 [0:SEQ_N-1];
    bit c_ref [0:PBCH_LEN-1];

    always #5 clk_i = ~clk_i;

    pbch_descrambler #(.LLR_DW(LLR_DW), .PBCH_LEN(PBCH_LEN), .N_ID_DW(N_ID_DW)) dut (
        .clk_i                 (clk_i),
        .reset_i               (reset_i),
        .N_id_i                (N_id_i),
        .N_id_valid_i          (N_id_valid_i),
        .ibar_SSB_i            (ibar_SSB_i),
        .ibar_SSB_valid_i      (ibar_SSB_valid_i),
        .s_axis_llr_in_tdata   (s_tdata),
        .s_axis_llr_in_tuser   (s_tuser),
        .s_axis_llr_in_tlast   (s_tlast),
        .s_axis_llr_in_tvalid  (s_tvalid),
        .m_axis_llr_out_tdata  (m_tdata),
        .m_axis_llr_out_tuser  (m_tuser),
        .m_axis_llr_out_tlast  (m_tlast),
        .m_axis_llr_out_tvalid (m_tvalid),
        .ready_o               (ready_o),
        .dropped_o             (dropped_o)
    );

    // Reference: c(n) = x1(n+Nc) xor x2(n+Nc), block uses c(v*M .. v*M+M-1).
    task automatic gen_ref(input int nid, input int v);
        for (int i = 0; i < 31; i++) begin
            x1[i] = (i == 0);
            x2[i] = ((nid >> i) & 1) != 0;
        end
        for (int n = 0; n + 31 < SEQ_N; n++) begin
            x1[n+31] = x1[n+3] ^ x1[n];
            x2[n+31] = x2[n+3] ^ x2[n+2] ^ x2[n+1] ^ x2[n];
        end
        for (int i = 0; i < PBCH_LEN; i++)
            c_ref[i] = x1[v*PBCH_LEN + i + NC_REF] ^ x2[v*PBCH_LEN + i + NC_REF];
    endtask

    function automatic logic [LLR_DW-1:0] exp_llr(input logic [LLR_DW-1:0] d, input bit c);
        int val;
        val = $signed(d);
        if (c) val = -val;
        if (val > 127) val = 127;
        return LLR_DW'(val);
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_beat(input logic [LLR_DW-1:0] d, input logic [1:0] u, input logic l);
        s_tdata = d; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
        tick();
        s_tvalid = 1'b0; s_tlast = 1'b0;
    endtask

    task automatic start_block(input int nid);
        cur_nid = nid;
        N_id_i = N_ID_DW'(nid); N_id_valid_i = 1'b1;
        tick();
        N_id_valid_i = 1'b0;
    endtask

    task automatic set_v(input int v);
        ibar_SSB_i = 3'(v); ibar_SSB_valid_i = 1'b1;
        tick();
        ibar_SSB_valid_i = 1'b0;
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (!ready_o && cyc < WAIT_MAX) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        N_id_i = '0; N_id_valid_i = 1'b0; ibar_SSB_i = '0; ibar_SSB_valid_i = 1'b0;
        s_tdata = 8'h80; s_tuser = 2'b11; s_tlast = 1'b1; s_tvalid = 1'b1;
        repeat (3) tick();
        vectors++; if (m_tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_tvalid got %b want 0", m_tvalid); end
        vectors++; if (m_tdata !== '0) begin miscompares++; $display("FAIL reset_tdata got %h want 00", m_tdata); end
        vectors++; if (m_tuser !== '0) begin miscompares++; $display("FAIL reset_tuser got %h want 0", m_tuser); end
        vectors++; if (m_tlast !== 1'b0) begin miscompares++; $display("FAIL reset_tlast got %b want 0", m_tlast); end
        vectors++; if (ready_o !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b want 0", ready_o); end
        vectors++; if (dropped_o !== 1'b0) begin miscompares++; $display("FAIL reset_dropped got %b want 0", dropped_o); end
        s_tvalid = 1'b0; s_tlast = 1'b0;
        reset_i = 1'b0;
        tick();
    endtask

    task automatic test_ready_latency();
        int cyc;
        start_block(0);
        wait_ready(cyc);
        vectors++;
        if (cyc !== NC_REF) begin miscompares++; $display("FAIL ready_latency got %0d want %0d", cyc, NC_REF); end
    endtask

    task automatic test_full_block();
        int cyc;
        logic [1:0] u;
        set_v(2);
        start_block(12'h155);
        wait_ready(cyc);
        vectors++;
        if (cyc !== NC_REF + 2*PBCH_LEN) begin miscompares++; $display("FAIL full_init_len got %0d want %0d", cyc, NC_REF + 2*PBCH_LEN); end
        gen_ref(12'h155, 2);
        for (int i = 0; i < PBCH_LEN; i++) begin
            u = 2'($urandom);
            send_beat(8'd5, u, 1'b0);
            vectors++;
            if ({m_tvalid, m_tdata, m_tuser, m_tlast} !== {1'b1, exp_llr(8'd5, c_ref[i]), u, (i == PBCH_LEN-1)}) begin
                miscompares++;
                $display("FAIL full_block beat %0d got v%b d%h u%h l%b want d%h u%h l%b", i,
                         m_tvalid, m_tdata, m_tuser, m_tlast, exp_llr(8'd5, c_ref[i]), u, (i == PBCH_LEN-1));
            end
        end
        wait_ready(cyc);
        vectors++;
        if (cyc !== NC_REF + 2*PBCH_LEN) begin miscompares++; $display("FAIL reinit_len got %0d want %0d", cyc, NC_REF + 2*PBCH_LEN); end
    endtask

    task automatic test_saturation();
        int cyc;
        logic [LLR_DW-1:0] d;
        set_v(0);
        start_block(int'($urandom_range(0, 1023)));
        wait_ready(cyc);
        vectors++;
        if (cyc !== NC_REF) begin miscompares++; $display("FAIL sat_init_len got %0d want %0d", cyc, NC_REF); end
        gen_ref(cur_nid, 0);
        for (int i = 0; i < 64; i++) begin
            case (i % 4)
                0, 1:    d = 8'h80;
                2:       d = 8'h00;
                default: d = 8'($urandom);
            endcase
            send_beat(d, 2'b01, (i == 63));
            vectors++;
            if ({m_tvalid, m_tdata, m_tlast} !== {1'b1, exp_llr(d, c_ref[i]), (i == 63)}) begin
                miscompares++;
                $display("FAIL saturation beat %0d in %h got v%b d%h l%b want d%h", i, d, m_tvalid, m_tdata, m_tlast, exp_llr(d, c_ref[i]));
            end
        end
    endtask

    task automatic test_drop_in_init();
        int cyc;
        logic [LLR_DW-1:0] d;
        for (int k = 0; k < 5; k++) begin
            send_beat(8'($urandom), 2'b10, 1'b0);
            vectors++;
            if ({m_tvalid, dropped_o} !== 2'b01) begin
                miscompares++; $display("FAIL drop_in_init beat %0d got valid %b dropped %b want 0 1", k, m_tvalid, dropped_o);
            end
        end
        tick();
        vectors++;
        if (dropped_o !== 1'b0) begin miscompares++; $display("FAIL drop_clear got %b want 0", dropped_o); end
        wait_ready(cyc);
        vectors++;
        if (cyc !== NC_REF - 6) begin miscompares++; $display("FAIL drop_init_len got %0d want %0d", cyc, NC_REF - 6); end
        gen_ref(cur_nid, 0);
        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom);
            send_beat(d, 2'b00, (i == 15));
            vectors++;
            if ({m_tvalid, m_tdata} !== {1'b1, exp_llr(d, c_ref[i])}) begin
                miscompares++; $display("FAIL restart beat %0d got %h want %h", i, m_tdata, exp_llr(d, c_ref[i]));
            end
        end
    endtask

    task automatic test_nid_override();
        int cyc, new_nid;
        logic [LLR_DW-1:0] d;
        wait_ready(cyc);
        gen_ref(cur_nid, 0);
        for (int i = 0; i < 10; i++) begin
            d = 8'($urandom);
            send_beat(d, 2'b00, 1'b0);
            vectors++;
            if ({m_tvalid, m_tdata} !== {1'b1, exp_llr(d, c_ref[i])}) begin
                miscompares++; $display("FAIL pre_override beat %0d got %h want %h", i, m_tdata, exp_llr(d, c_ref[i]));
            end
        end
        new_nid = int'($urandom_range(0, 1023));
        N_id_i = N_ID_DW'(new_nid); N_id_valid_i = 1'b1;
        send_beat(8'h33, 2'b00, 1'b0);
        N_id_valid_i = 1'b0;
        cur_nid = new_nid;
        vectors++;
        if ({m_tvalid, dropped_o, ready_o} !== 3'b010) begin
            miscompares++; $display("FAIL override_drop got v%b drop%b rdy%b want 0 1 0", m_tvalid, dropped_o, ready_o);
        end
        wait_ready(cyc);
        vectors++;
        if (cyc !== NC_REF) begin miscompares++; $display("FAIL override_init_len got %0d want %0d", cyc, NC_REF); end
        gen_ref(new_nid, 0);
        for (int i = 0; i < 20; i++) begin
            d = 8'($urandom);
            send_beat(d, 2'b11, (i == 19));
            vectors++;
            if ({m_tvalid, m_tdata} !== {1'b1, exp_llr(d, c_ref[i])}) begin
                miscompares++; $display("FAIL post_override beat %0d got %h want %h", i, m_tdata, exp_llr(d, c_ref[i]));
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        logic [LLR_DW-1:0] d;
        set_v(1);
        start_block(int'($urandom_range(0, 1023)));
        wait_ready(cyc);
        vectors++;
        if (cyc !== NC_REF + PBCH_LEN) begin miscompares++; $display("FAIL v1_init_len got %0d want %0d", cyc, NC_REF + PBCH_LEN); end
        gen_ref(cur_nid, 1);
        for (int i = 0; i < 400; i++) begin
            d = 8'($urandom);
            send_beat(d, 2'b01, 1'b0);
            vectors++;
            if ({m_tvalid, m_tdata} !== {1'b1, exp_llr(d, c_ref[i])}) begin
                miscompares++; $display("FAIL v1_block beat %0d got %h want %h", i, m_tdata, exp_llr(d, c_ref[i]));
            end
        end
        s_tdata = 8'h7F; s_tuser = 2'b11; s_tvalid = 1'b1;
        reset_i = 1'b1;
        #1;
        vectors++;
        if ({m_tvalid, m_tdata, m_tuser, m_tlast, ready_o, dropped_o} !== '0) begin
            miscompares++; $display("FAIL async_reset got v%b d%h u%h l%b r%b dr%b want all 0",
                                    m_tvalid, m_tdata, m_tuser, m_tlast, ready_o, dropped_o);
        end
        tick();
        reset_i = 1'b0;
        for (int k = 0; k < 20; k++) begin
            send_beat(8'($urandom), 2'b01, 1'b0);
            vectors++;
            if ({m_tvalid, ready_o} !== 2'b00) begin
                miscompares++; $display("FAIL post_reset_quiet cycle %0d got v%b r%b want 0 0", k, m_tvalid, ready_o);
            end
        end
        start_block(cur_nid);
        wait_ready(cyc);
        vectors++;
        if (cyc !== NC_REF) begin miscompares++; $display("FAIL post_reset_v_cleared got %0d want %0d", cyc, NC_REF); end
        gen_ref(cur_nid, 0);
        for (int i = 0; i < 32; i++) begin
            d = 8'($urandom);
            send_beat(d, 2'b00, (i == 31));
            vectors++;
            if ({m_tvalid, m_tdata, m_tlast} !== {1'b1, exp_llr(d, c_ref[i]), (i == 31)}) begin
                miscompares++; $display("FAIL post_reset_block beat %0d got %h want %h", i, m_tdata, exp_llr(d, c_ref[i]));
            end
        end
    endtask

    task automatic test_back_to_back();
        int cyc, v1, v2, len;
        logic [LLR_DW-1:0] d;
        v1 = int'($urandom_range(0, 3));
        v2 = (v1 + 1 + int'($urandom_range(0, 2))) % 4;
        set_v(v1);
        start_block(int'($urandom_range(0, 1023)));
        wait_ready(cyc);
        vectors++;
        if (cyc !== NC_REF + v1*PBCH_LEN) begin miscompares++; $display("FAIL b2b_init1 got %0d want %0d", cyc, NC_REF + v1*PBCH_LEN); end
        gen_ref(cur_nid, v1);
        len = int'($urandom_range(8, 40));
        for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                tick();
                vectors++;
                if (m_tvalid !== 1'b0) begin miscompares++; $display("FAIL b2b_gap got %b want 0", m_tvalid); end
            end
            d = 8'($urandom);
            if (i == 3) begin ibar_SSB_i = 3'(v2); ibar_SSB_valid_i = 1'b1; end
            send_beat(d, 2'b10, (i == len-1));
            ibar_SSB_valid_i = 1'b0;
            vectors++;
            if ({m_tvalid, m_tdata, m_tlast} !== {1'b1, exp_llr(d, c_ref[i]), (i == len-1)}) begin
                miscompares++; $display("FAIL b2b_block1 beat %0d got %h want %h", i, m_tdata, exp_llr(d, c_ref[i]));
            end
        end
        wait_ready(cyc);
        vectors++;
        if (cyc !== NC_REF + v2*PBCH_LEN) begin miscompares++; $display("FAIL b2b_init2 got %0d want %0d", cyc, NC_REF + v2*PBCH_LEN); end
        gen_ref(cur_nid, v2);
        for (int i = 0; i < 24; i++) begin
            d = 8'($urandom);
            send_beat(d, 2'b01, (i == 23));
            vectors++;
            if ({m_tvalid, m_tdata, m_tlast} !== {1'b1, exp_llr(d, c_ref[i]), (i == 23)}) begin
                miscompares++; $display("FAIL b2b_block2 beat %0d got %h want %h", i, m_tdata, exp_llr(d, c_ref[i]));
            end
        end
    endtask

    initial begin
        test_reset();
        test_ready_latency();
        test_full_block();
        test_saturation();
        test_drop_in_init();
        test_nid_override();
        test_reset_mid_run();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
